// File: rtl/chicken_pkg.sv
`default_nettype none
// ============================================================================
//  Package     : chicken_pkg
//  Description : Shared constants for the chicken board game-flow blocks:
//                turn-sequencer state encoding, player codes and the
//                player-rotation helper.
//  Revision    : 1.0  initial release
// ============================================================================
package chicken_pkg;

    // Turn-sequencer state encoding (3-bit, shared with display logic)
    localparam logic [2:0] ST_IDLE      = 3'd0;
    localparam logic [2:0] ST_WAIT_FLIP = 3'd1;
    localparam logic [2:0] ST_REVEAL    = 3'd2;
    localparam logic [2:0] ST_JUDGE     = 3'd3;
    localparam logic [2:0] ST_MOVE      = 3'd4;
    localparam logic [2:0] ST_SETTLE    = 3'd5;
    localparam logic [2:0] ST_CHECK     = 3'd6;
    localparam logic [2:0] ST_GAME_OVER = 3'd7;

    // Player codes; code 0 never names a real player
    localparam logic [1:0] PLAYER_NONE  = 2'd0;
    localparam logic [1:0] PLAYER_FIRST = 2'd1;

    // Hand the turn to the next player, wrapping from the last one to the first
    function automatic logic [1:0] next_player(input logic [1:0] cur,
                                               input logic [1:0] last);
        return (cur == last) ? PLAYER_FIRST : cur + 2'd1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/cycle_timer.sv
`default_nettype none
// ============================================================================
//  Module      : cycle_timer
//  Description : Counts enabled cycles since the last load; done is high in
//                the LIMIT-th enabled cycle, after which the count restarts.
//  Revision    : 1.0  initial release
// ============================================================================
module cycle_timer #(
    parameter int LIMIT = 1
) (
    input  logic clk,
    input  logic rst,
    input  logic load,
    input  logic enable,
    output logic done
);

    localparam int CW = $clog2(LIMIT + 1);

    logic [CW-1:0] count_q;
    logic [CW-1:0] count_d;

    // Expiry is flagged during the last counted cycle so the owner can act on the same edge
    assign done = enable && !load && (count_q == CW'(LIMIT - 1));

    // Next count: restart on load or expiry, otherwise advance while enabled
    always_comb begin
        count_d = count_q;
        if (load || done) begin
            count_d = '0;
        end else if (enable) begin
            count_d = count_q + CW'(1);
        end
    end

    // Count register with synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

endmodule
`default_nettype wire

// File: rtl/turn_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : turn_sequencer
//  Description : Game-flow controller for the chicken board. Owns the current
//                player T, runs each turn (flip, reveal, judge, move, win
//                check) and issues the clear / move pulses for the position
//                counters. All outputs are registered.
//  Revision    : 1.0  initial release
// ============================================================================
module turn_sequencer
    import chicken_pkg::*;
#(
    parameter int NUM_PLAYERS    = 3,
    parameter int REVEAL_CYCLES  = 50_000_000,
    parameter int TIMEOUT_CYCLES = 500_000_000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic       B,
    input  logic       match,
    input  logic       W,
    output logic [1:0] T,
    output logic       clr,
    output logic       move_en,
    output logic       reveal,
    output logic       game_over,
    output logic [1:0] winner
);

    localparam logic [1:0] LAST_PLAYER = 2'(NUM_PLAYERS);

    logic [2:0] state_q,     state_d;
    logic [1:0] t_q,         t_d;
    logic [1:0] winner_q,    winner_d;
    logic       clr_q,       clr_d;
    logic       move_en_q,   move_en_d;
    logic       reveal_q,    reveal_d;
    logic       game_over_q, game_over_d;

    logic reveal_done;
    logic timeout_done;

    // Reveal timer: held in reload outside REVEAL so every reveal lasts the full period
    cycle_timer #(
        .LIMIT (REVEAL_CYCLES)
    ) u_reveal_timer (
        .clk    (clk),
        .rst    (rst),
        .load   (state_q != ST_REVEAL),
        .enable (state_q == ST_REVEAL),
        .done   (reveal_done)
    );

    // Turn-timeout timer: only runs while waiting for a flip; absent when disabled
    generate
        if (TIMEOUT_CYCLES > 0) begin : g_timeout
            cycle_timer #(
                .LIMIT (TIMEOUT_CYCLES)
            ) u_timeout_timer (
                .clk    (clk),
                .rst    (rst),
                .load   (state_q != ST_WAIT_FLIP),
                .enable (state_q == ST_WAIT_FLIP),
                .done   (timeout_done)
            );
        end else begin : g_no_timeout
            assign timeout_done = 1'b0;
        end
    endgenerate

    // State, player, winner and output registers
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q     <= ST_IDLE;
            t_q         <= PLAYER_FIRST;
            winner_q    <= PLAYER_NONE;
            clr_q       <= 1'b0;
            move_en_q   <= 1'b0;
            reveal_q    <= 1'b0;
            game_over_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            t_q         <= t_d;
            winner_q    <= winner_d;
            clr_q       <= clr_d;
            move_en_q   <= move_en_d;
            reveal_q    <= reveal_d;
            game_over_q <= game_over_d;
        end
    end

    // Next state, turn rotation and winner capture
    always_comb begin
        state_d  = state_q;
        t_d      = t_q;
        winner_d = winner_q;
        case (state_q)
            ST_IDLE, ST_GAME_OVER: begin
                if (start) begin
                    state_d  = ST_WAIT_FLIP;
                    t_d      = PLAYER_FIRST;
                    winner_d = PLAYER_NONE;
                end
            end
            ST_WAIT_FLIP: begin
                // A flip takes priority over a simultaneous timeout
                if (B) begin
                    state_d = ST_REVEAL;
                end else if (timeout_done) begin
                    t_d = next_player(t_q, LAST_PLAYER);
                end
            end
            ST_REVEAL: begin
                if (reveal_done) begin
                    state_d = ST_JUDGE;
                end
            end
            ST_JUDGE: begin
                if (match) begin
                    state_d = ST_MOVE;
                end else begin
                    state_d = ST_WAIT_FLIP;
                    t_d     = next_player(t_q, LAST_PLAYER);
                end
            end
            ST_MOVE: begin
                state_d = ST_SETTLE;
            end
            ST_SETTLE: begin
                state_d = ST_CHECK;
            end
            ST_CHECK: begin
                // No win keeps the same player for a bonus flip
                if (W) begin
                    state_d  = ST_GAME_OVER;
                    winner_d = t_q;
                end else begin
                    state_d = ST_WAIT_FLIP;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Registered outputs decoded from the state being entered
    always_comb begin
        clr_d       = ((state_q == ST_IDLE) || (state_q == ST_GAME_OVER)) && start;
        move_en_d   = (state_d == ST_MOVE);
        reveal_d    = (state_d == ST_REVEAL);
        game_over_d = (state_d == ST_GAME_OVER);
    end

    assign T         = t_q;
    assign winner    = winner_q;
    assign clr       = clr_q;
    assign move_en   = move_en_q;
    assign reveal    = reveal_q;
    assign game_over = game_over_q;

endmodule
`default_nettype wire

// File: tb/tb_turn_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_turn_sequencer
//  Description : Self-checking bench for turn_sequencer with a turn-level
//                reference model compared on every cycle, plus directed
//                scenario checks with hand-computed values.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_turn_sequencer;

    localparam int NP = 3;
    localparam int RC = 4;
    localparam int TO = 10;

    logic       clk;
    logic       rst;
    logic       start;
    logic       B;
    logic       match;
    logic       W;
    logic [1:0] T;
    logic       clr;
    logic       move_en;
    logic       reveal;
    logic       game_over;
    logic [1:0] winner;

    int checks = 0;
    int errors = 0;

    turn_sequencer #(
        .NUM_PLAYERS    (NP),
        .REVEAL_CYCLES  (RC),
        .TIMEOUT_CYCLES (TO)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .B         (B),
        .match     (match),
        .W         (W),
        .T         (T),
        .clr       (clr),
        .move_en   (move_en),
        .reveal    (reveal),
        .game_over (game_over),
        .winner    (winner)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ------------------------------------------------------------------
    // Turn-level reference model: phase name + cycles spent in it
    // ------------------------------------------------------------------
    typedef enum int {P_IDLE, P_WAIT, P_SHOW, P_JUDGE, P_MOVE, P_SETTLE, P_CHECK, P_OVER} phase_t;
    phase_t     m_ph  = P_IDLE;
    int         m_cnt = 0;
    logic [1:0] m_t   = 2'd1;
    logic [1:0] m_win = 2'd0;
    bit         m_clr = 1'b0;
    bit         armed = 1'b0;

    function automatic logic [1:0] rot(input logic [1:0] p);
        return (int'(p) == NP) ? 2'd1 : p + 2'd1;
    endfunction

    always @(posedge clk) begin
        m_clr = 1'b0;
        if (!rst) begin
            m_ph  = P_IDLE;
            m_cnt = 0;
            m_t   = 2'd1;
            m_win = 2'd0;
            armed = 1'b1;
        end else begin
            case (m_ph)
                P_IDLE, P_OVER: if (start) begin
                    m_clr = 1'b1; m_t = 2'd1; m_win = 2'd0; m_ph = P_WAIT; m_cnt = 0;
                end
                P_WAIT: begin
                    if (B) begin
                        m_ph = P_SHOW; m_cnt = 0;
                    end else begin
                        m_cnt++;
                        if (m_cnt == TO) begin m_t = rot(m_t); m_cnt = 0; end
                    end
                end
                P_SHOW: begin
                    m_cnt++;
                    if (m_cnt == RC) m_ph = P_JUDGE;
                end
                P_JUDGE: if (match) m_ph = P_MOVE;
                         else begin m_t = rot(m_t); m_ph = P_WAIT; m_cnt = 0; end
                P_MOVE:   m_ph = P_SETTLE;
                P_SETTLE: m_ph = P_CHECK;
                P_CHECK:  if (W) begin m_win = m_t; m_ph = P_OVER; end
                          else begin m_ph = P_WAIT; m_cnt = 0; end
                default:  m_ph = P_IDLE;
            endcase
        end
    end

    // Per-cycle comparison against the model, plus pulse bookkeeping
    int n_move   = 0;
    int n_clr    = 0;
    int n_reveal = 0;

    always @(negedge clk) begin
        if (armed) begin
            check("T",         32'(T),         32'(m_t));
            check("winner",    32'(winner),    32'(m_win));
            check("clr",       32'(clr),       32'(m_clr));
            check("move_en",   32'(move_en),   32'(m_ph == P_MOVE));
            check("reveal",    32'(reveal),    32'(m_ph == P_SHOW));
            check("game_over", 32'(game_over), 32'(m_ph == P_OVER));
            check("clr_and_move_exclusive", 32'(clr && move_en), 32'd0);
            if (move_en) n_move++;
            if (clr)     n_clr++;
            if (reveal)  n_reveal++;
        end
    end

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic pulse_start();
        start = 1'b1; cyc(1); start = 1'b0;
    endtask

    task automatic pulse_b();
        B = 1'b1; cyc(1); B = 1'b0;
    endtask

    initial begin
        int waited;
        rst = 1'b0; start = 1'b0; B = 1'b0; match = 1'b0; W = 1'b0;

        // 1: reset, then B in IDLE is ignored
        cyc(2);
        rst = 1'b1;
        check("rst_T", 32'(T), 32'd1);
        check("rst_outputs", {26'd0, clr, move_en, reveal, game_over, winner}, 32'd0);
        pulse_b();
        cyc(3);
        check("idle_B_ignored_reveal", 32'(reveal), 32'd0);

        // 2: start, flip with match, no win
        n_clr = 0; n_reveal = 0; n_move = 0;
        match = 1'b1; W = 1'b0;
        pulse_start();
        check("start_clr_pulse", 32'(clr), 32'd1);
        pulse_b();
        cyc(9);
        check("s2_clr_once", 32'(n_clr), 32'd1);
        check("s2_reveal_cycles", 32'(n_reveal), 32'd4);
        check("s2_move_once", 32'(n_move), 32'd1);
        check("s2_T_kept", 32'(T), 32'd1);

        // 3: three failed flips rotate the turn
        match = 1'b0;
        pulse_b(); cyc(6); check("s3_T_2", 32'(T), 32'd2);
        pulse_b(); cyc(6); check("s3_T_3", 32'(T), 32'd3);
        pulse_b(); cyc(6); check("s3_T_1", 32'(T), 32'd1);
        check("s3_no_move", 32'(n_move), 32'd1);

        // 4: timeout rotation, then a flip on the expiry cycle wins
        waited = 0;
        while (T == 2'd1 && waited < 20) begin cyc(1); waited++; end
        check("s4_timeout_seen", 32'(waited < 20), 32'd1);
        check("s4_T_2", 32'(T), 32'd2);
        cyc(9);
        pulse_b();
        check("s4_B_on_expiry_T", 32'(T), 32'd2);
        check("s4_B_on_expiry_reveal", 32'(reveal), 32'd1);

        // 5: this flip matches and wins for player 2
        match = 1'b1; W = 1'b1;
        cyc(8);
        check("s5_game_over", 32'(game_over), 32'd1);
        check("s5_winner", 32'(winner), 32'd2);
        match = 1'b0; W = 1'b0;
        pulse_b(); cyc(6);
        check("s5_B_ignored", 32'(reveal), 32'd0);
        check("s5_winner_frozen", 32'(winner), 32'd2);
        pulse_start();
        check("s5_restart_clr", 32'(clr), 32'd1);
        check("s5_restart_winner", 32'(winner), 32'd0);
        check("s5_restart_T", 32'(T), 32'd1);

        // 6: reset during REVEAL aborts the turn
        n_move = 0;
        match = 1'b1;
        pulse_b(); cyc(2);
        check("s6_in_reveal", 32'(reveal), 32'd1);
        rst = 1'b0;
        cyc(1);
        check("s6_reveal_cleared", 32'(reveal), 32'd0);
        check("s6_T_reset", 32'(T), 32'd1);
        rst = 1'b1;
        cyc(10);
        check("s6_no_move", 32'(n_move), 32'd0);
        check("s6_idle_no_game_over", 32'(game_over), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    // Watchdog so the bench always terminates
    initial begin
        #100000;
        $display("FAIL watchdog: simulation still running at %0t, expected completion", $time);
        $fatal(1);
    end

endmodule
`default_nettype wire
